// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial little-endian program loader.
// The core is held in reset until a load completes; the fetch port reads combinationally.
module instr_mem_loader #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [31:0]       instr_out,
    output logic              core_rst_n,
    output logic              load_done,
    output logic [7:0]        word_count,
    output logic              overflow
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 24;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W  = 32;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [1:0]          byte_idx;
    logic [LANE_W-1:0]   lanes;
    logic [WORD_W-1:0]   mem [DEPTH];

    logic                enter_load;
    logic                take_byte;
    logic                word_done;
    logic                mem_we;
    logic                rd_hit;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control
    always_comb begin
        next_state = state;
        enter_load = 1'b0;
        take_byte  = 1'b0;
        word_done  = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    next_state = LOAD;
                    enter_load = 1'b1;
                end
            end
            LOAD: begin
                // A byte presented while load_en falls is discarded.
                if (!load_en) begin
                    next_state = RUN;
                end else begin
                    take_byte = byte_valid;
                end
            end
            RUN: begin
                if (load_en) begin
                    next_state = LOAD;
                    enter_load = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        word_done = take_byte && (byte_idx == 2'd3);
        mem_we    = word_done && (word_count < DEPTH_CNT);
    end

    // Byte packing, word counting and core reset control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx   <= 2'd0;
            lanes      <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            core_rst_n <= (next_state == RUN);
            load_done  <= (next_state == RUN);
            if (enter_load) begin
                byte_idx   <= 2'd0;
                word_count <= '0;
                overflow   <= 1'b0;
            end else if (take_byte) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    lanes[7:0]   <= byte_in;
                    2'd1:    lanes[15:8]  <= byte_in;
                    2'd2:    lanes[23:16] <= byte_in;
                    default: lanes        <= lanes;
                endcase
                if (word_done) begin
                    if (mem_we) begin
                        word_count <= word_count + CNT_W'(1);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
            end
        end
    end

    // Program storage; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[IDX_W'(word_count)] <= {byte_in, lanes};
        end
    end

    // Only words written by the most recent load are visible
    assign rd_hit    = (CMP_W'(fetch_addr) < CMP_W'(word_count));
    assign instr_out = rd_hit ? mem[IDX_W'(fetch_addr)] : '0;

endmodule
